// File: rtl/pg_carry_resolver_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package    : adder_pkg                                             |
// | Description: Shared carry-lookahead group width, group p/g term    |
// |              type and the associative p/g combine operator.        |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
package adder_pkg;

    localparam int GROUP_W = 4;

    // Group-level generate/propagate pair.
    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    // Combine a higher-order span (hi) with the lower-order span (lo)
    // directly beneath it: the merged span generates if hi generates or
    // hi propagates a carry generated by lo.
    function automatic pg_t pg_combine(input pg_t hi, input pg_t lo);
        pg_t v_r;
        v_r.g = hi.g | (hi.p & lo.g);
        v_r.p = hi.p & lo.p;
        return v_r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pg_carry_resolver_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface  : pg_carry_resolver_if                                  |
// | Description: Valid/ready input (p/g/cin) and output (sum/cout/ovf) |
// |              bundle for the carry resolver.                        |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
interface pg_carry_resolver_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    // Producer of operations / consumer of results.
    modport master (
        output in_valid, p, g, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    // The resolver itself.
    modport slave (
        input  in_valid, p, g, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface
`default_nettype wire

// File: rtl/pg_carry_resolver_cla_group4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : cla_group4                                            |
// | Description: Combinational 4-bit lookahead. Produces the group     |
// |              generate/propagate and, for every bit, the carry into |
// |              that bit assuming a zero group carry-in (pre_g) plus  |
// |              the propagate product of the bits below it (pre_p).   |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
module cla_group4
    import adder_pkg::*;
(
    input  wire  [GROUP_W-1:0] i_p,
    input  wire  [GROUP_W-1:0] i_g,
    output pg_t                o_grp,
    output logic [GROUP_W-1:0] o_pre_g,
    output logic [GROUP_W-1:0] o_pre_p
);

    // Prefix scan from bit 0 upward; the running span before bit j is
    // exactly that bit's in-group prefix term.
    always_comb begin
        pg_t v_acc;
        pg_t v_bit;
        v_acc.g = 1'b0;
        v_acc.p = 1'b1;
        v_bit   = '0;
        o_pre_g = '0;
        o_pre_p = '0;
        for (int j = 0; j < GROUP_W; j++) begin
            o_pre_g[j] = v_acc.g;
            o_pre_p[j] = v_acc.p;
            v_bit.g    = i_g[j];
            v_bit.p    = i_p[j];
            v_acc      = pg_combine(v_bit, v_acc);
        end
        o_grp = v_acc;
    end

endmodule
`default_nettype wire

// File: rtl/pg_carry_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : pg_carry_resolver                                     |
// | Description: Two-stage valid/ready pipeline turning per-bit p/g    |
// |              vectors into sum, carry-out and signed overflow using |
// |              4-bit lookahead groups chained in the second stage.   |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
module pg_carry_resolver
    import adder_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input wire                 clk,
    input wire                 rst,
    pg_carry_resolver_if.slave bus
);

    localparam int c_num_grp = WIDTH / GROUP_W;

    // Stage-1 combinational group terms
    pg_t  [c_num_grp-1:0] w_grp;
    logic [WIDTH-1:0]     w_pre_g;
    logic [WIDTH-1:0]     w_pre_p;

    // Stage-1 registers
    logic                 r_s1_v;
    logic [WIDTH-1:0]     r_s1_p;
    logic                 r_s1_cin;
    pg_t  [c_num_grp-1:0] r_s1_grp;
    logic [WIDTH-1:0]     r_s1_pre_g;
    logic [WIDTH-1:0]     r_s1_pre_p;

    // Stage-2 combinational resolution
    logic [WIDTH-1:0]     w_carry;
    logic                 w_cout;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_ovf;

    // Stage-2 registers
    logic                 r_s2_v;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_ovf;

    // Stall control
    logic                 w_s2_en;
    logic                 w_s1_en;

    assign w_s2_en = !r_s2_v || bus.out_ready;
    assign w_s1_en = !r_s1_v || w_s2_en;

    // Masking with rst guarantees no handshake completes while the
    // pipeline is being flushed.
    assign bus.in_ready  = w_s1_en && !rst;
    assign bus.out_valid = r_s2_v  && !rst;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

    generate
        for (genvar gk = 0; gk < c_num_grp; gk++) begin : g_grp
            cla_group4 u_cla (
                .i_p     (bus.p[gk*GROUP_W +: GROUP_W]),
                .i_g     (bus.g[gk*GROUP_W +: GROUP_W]),
                .o_grp   (w_grp[gk]),
                .o_pre_g (w_pre_g[gk*GROUP_W +: GROUP_W]),
                .o_pre_p (w_pre_p[gk*GROUP_W +: GROUP_W])
            );
        end
    endgenerate

    // Stage 1: capture group terms, propagate vector and carry-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s1_p     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_grp   <= '0;
            r_s1_pre_g <= '0;
            r_s1_pre_p <= '0;
        end else if (w_s1_en) begin
            r_s1_v     <= bus.in_valid;
            r_s1_p     <= bus.p;
            r_s1_cin   <= bus.cin;
            r_s1_grp   <= w_grp;
            r_s1_pre_g <= w_pre_g;
            r_s1_pre_p <= w_pre_p;
        end
    end

    // Ripple the group carries and expand each into its per-bit carries.
    always_comb begin
        logic v_c;
        v_c     = r_s1_cin;
        w_carry = '0;
        for (int k = 0; k < c_num_grp; k++) begin
            for (int j = 0; j < GROUP_W; j++) begin
                w_carry[k*GROUP_W + j] = r_s1_pre_g[k*GROUP_W + j]
                                       | (r_s1_pre_p[k*GROUP_W + j] & v_c);
            end
            v_c = r_s1_grp[k].g | (r_s1_grp[k].p & v_c);
        end
        w_cout = v_c;
    end

    // w_carry[0] is cin itself, so this is p ^ {carries[WIDTH-1:1], cin}.
    assign w_sum = r_s1_p ^ w_carry;
    assign w_ovf = w_carry[WIDTH-1] ^ w_cout;

    // Stage 2: register the result; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_v <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_s2_en) begin
            r_s2_v <= r_s1_v;
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pg_carry_resolver.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module     : tb_pg_carry_resolver                                  |
// | Description: Scoreboard bench; expected results come from integer  |
// |              addition of the operands that generated p/g.          |
// | Revision   : 1.0  initial release                                  |
// +--------------------------------------------------------------------+
module tb_pg_carry_resolver;

    localparam int W      = 32;
    localparam int N_RAND = 10000;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic [31:0]  cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = '0;

    pg_carry_resolver_if #(.WIDTH(W)) bus ();

    pg_carry_resolver #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int           total    = 0;
    int           bad      = 0;
    int           accepted = 0;
    int           run_len  = 0;
    int           max_run  = 0;
    logic         lat_exact = 1'b1;
    exp_t         q[$];
    logic [W-1:0] cur_a, cur_b;
    logic         cur_cin;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer addition of the original operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        logic [W:0] full;
        exp_t       e;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == b[W-1]) && (e.sum[W-1] != a[W-1]);
        e.cyc  = '0;
        return e;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        cur_a        = a;
        cur_b        = b;
        cur_cin      = ci;
        bus.in_valid = v;
        bus.p        = a ^ b;
        bus.g        = a & b;
        bus.cin      = ci;
    endtask

    // Present an op (from posedge+1) and wait for its acceptance; returns at posedge+1.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic chk_ready);
        int t;
        drive(1'b1, a, b, ci);
        @(negedge clk);
        if (chk_ready) check("b2b_in_ready", bus.in_ready, 1);
        t = 0;
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: actual in_ready=0 required=1 within 50 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard push: record every input-side transfer.
    initial begin : sb_push
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                e     = model(cur_a, cur_b, cur_cin);
                e.cyc = cyc;
                q.push_back(e);
                accepted++;
            end
        end
    end

    // Monitor: compare every output-side transfer, check held outputs.
    initial begin : sb_mon
        exp_t         e;
        logic         hold;
        logic [W-1:0] h_sum;
        logic         h_cout, h_ovf;
        hold = 1'b0;
        h_sum = '0;
        h_cout = 1'b0;
        h_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold    = 1'b0;
                run_len = 0;
            end else begin
                if (hold) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_sum", bus.sum, h_sum);
                    check("hold_flags", {bus.cout, bus.ovf}, {h_cout, h_ovf});
                end
                if (bus.out_valid === 1'b1) run_len++;
                else run_len = 0;
                if (run_len > max_run) max_run = run_len;
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: actual sum=%0h required=no result", bus.sum);
                    end else begin
                        e = q.pop_front();
                        check("sum", bus.sum, e.sum);
                        check("cout", bus.cout, e.cout);
                        check("ovf", bus.ovf, e.ovf);
                        if (lat_exact) check("latency", cyc - e.cyc, 2);
                    end
                end
                hold   = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
                h_sum  = bus.sum;
                h_cout = bus.cout;
                h_ovf  = bus.ovf;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          cycles;
        int          target;
        logic        did_rst;
        logic [W-1:0] a, b;

        bus.out_ready = 1'b1;
        lat_exact     = 1'b1;
        drive(1'b1, 32'h0000_0001, 32'h0000_0001, 1'b0);

        // Reset with in_valid held high
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", bus.out_valid, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_sum", bus.sum, 0);
        check("post_rst_flags", {bus.cout, bus.ovf}, 2'b00);
        @(posedge clk);
        #1 drive(1'b0, '0, '0, 1'b0);

        // Directed corner cases
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        send(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        drain();

        // Back-to-back stream of 8
        max_run = 0;
        for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        drain();
        check("b2b_run", max_run, 8);

        // Stall: out_ready low for 5 cycles while feeding ops
        lat_exact     = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, (i < 2) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        @(negedge clk);
        check("release_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        drain();

        // Random throttled traffic with a mid-stream reset
        target  = accepted + N_RAND;
        cycles  = 0;
        did_rst = 1'b0;
        while (accepted < target && cycles < 60000) begin
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? ~a : $urandom;
            drive(1'($urandom_range(0, 9) < 7), a, b, 1'($urandom_range(0, 1)));
            bus.out_ready = 1'($urandom_range(0, 9) < 7);
            if (!did_rst && accepted >= target - N_RAND / 2) begin
                did_rst = 1'b1;
                rst     = 1'b1;
                q.delete();
                repeat (2) begin
                    @(negedge clk);
                    check("midrst_out_valid", bus.out_valid, 0);
                    @(posedge clk);
                    #1;
                end
                rst = 1'b0;
                @(negedge clk);
                check("midrst_release_valid", bus.out_valid, 0);
            end else begin
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        if (cycles >= 60000) begin
            total++;
            bad++;
            $display("FAIL random_budget: actual accepted=%0d required=%0d", accepted, target);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
